// File: rtl/sysarb_pkg.sv
// Shared types for the system bus arbiter: FSM state encoding, the monitored Z80 master bus
// bundle and a width helper.
package sysarb_pkg;

   typedef enum logic [1:0] {
      StPark,
      StDrain,
      StTurn,
      StGrant
   } arb_state_t;

   // Subset of the mux master_out bundle; only the strobes matter for idle detection.
   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  dout;
      logic        mreqn;
      logic        iorqn;
      logic        rdn;
      logic        wrn;
      logic        inta;
   } z80_master_bus_t;

   function automatic int unsigned clamp_low(input int unsigned v, input int unsigned lo);
      return (v < lo) ? lo : v;
   endfunction

endpackage

// File: rtl/sysarb_rr_pick.sv
// Combinational round-robin picker over requesters 1..QTY-1, starting at ptr and wrapping.
// Bit 0 (the parked CPU) never wins.
module sysarb_rr_pick #(
   parameter int unsigned QTY = 2,
   parameter int unsigned W   = 1
) (
   input  logic [QTY-1:0] req,
   input  logic [W-1:0]   ptr,
   output logic           valid,
   output logic [W-1:0]   idx
);

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      // First pass covers ptr..QTY-1, second pass wraps around to 1..ptr-1.
      for (int unsigned i = 1; i < QTY; i++) begin
         if (!valid && req[i] && (i >= 32'(ptr))) begin
            valid = 1'b1;
            idx   = W'(i);
         end
      end
      for (int unsigned i = 1; i < QTY; i++) begin
         if (!valid && req[i] && (i < 32'(ptr))) begin
            valid = 1'b1;
            idx   = W'(i);
         end
      end
   end

endmodule

// File: rtl/sysarb.sv
// System bus arbiter: CPU (master 0) is the parked owner, other masters are granted round-robin
// with a quiet-bus drain and a fixed turnaround gap between owners.
module sysarb
   import sysarb_pkg::*;
#(
   parameter int unsigned MASTER_QTY  = 2,
   parameter int unsigned TURN_CYCLES = 1,
   parameter int unsigned MSEL_W      = clamp_low($clog2(MASTER_QTY), 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [MASTER_QTY-1:0] req_n,
   output logic [MASTER_QTY-1:0] ack_n,
   output logic                  cpu_busrq_n,
   input  logic                  cpu_busack_n,
   input  z80_master_bus_t       bus_mon,
   output logic [MSEL_W-1:0]     msel,
   output logic                  turn
);

   localparam int unsigned TcntW = clamp_low($clog2(TURN_CYCLES), 1);
   localparam logic [MASTER_QTY-1:0] ReqMask = ~MASTER_QTY'(1);

   arb_state_t              state_q, state_d;
   logic [MSEL_W-1:0]       msel_q, msel_d;
   logic [MSEL_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [TcntW-1:0]        tcnt_q, tcnt_d;
   logic [MASTER_QTY-1:0]   ack_n_q, ack_n_d;
   logic                    busrq_n_q, busrq_n_d;

   logic [MASTER_QTY-1:0]   req;
   logic                    any_req;
   logic                    idle;
   logic                    pick_valid;
   logic [MSEL_W-1:0]       pick_idx;
   logic                    unused_bus;

   assign req        = ~req_n & ReqMask;
   assign any_req    = |req;
   assign idle       = bus_mon.rdn & bus_mon.wrn & ~bus_mon.inta;
   assign unused_bus = ^{bus_mon.addr, bus_mon.dout, bus_mon.mreqn, bus_mon.iorqn};

   sysarb_rr_pick #(
      .QTY (MASTER_QTY),
      .W   (MSEL_W)
   ) u_rr_pick (
      .req   (req),
      .ptr   (rr_ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StPark;
         msel_q    <= '0;
         rr_ptr_q  <= MSEL_W'(1);
         tcnt_q    <= '0;
         ack_n_q   <= '1;
         busrq_n_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         msel_q    <= msel_d;
         rr_ptr_q  <= rr_ptr_d;
         tcnt_q    <= tcnt_d;
         ack_n_q   <= ack_n_d;
         busrq_n_q <= busrq_n_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      msel_d    = msel_q;
      rr_ptr_d  = rr_ptr_q;
      tcnt_d    = tcnt_q;
      ack_n_d   = ack_n_q;
      busrq_n_d = busrq_n_q;
      unique case (state_q)
         StPark: begin
            if (any_req) begin
               busrq_n_d = 1'b0;
               state_d   = StDrain;
            end
         end
         StDrain: begin
            // msel still names the outgoing owner; the CPU must also hand over via BUSACK_n.
            if (idle && ((msel_q != '0) || !cpu_busack_n)) begin
               tcnt_d  = TcntW'(TURN_CYCLES - 1);
               state_d = StTurn;
            end
         end
         StTurn: begin
            if (tcnt_q == '0) begin
               if (pick_valid) begin
                  msel_d            = pick_idx;
                  ack_n_d[pick_idx] = 1'b0;
                  rr_ptr_d = (pick_idx == MSEL_W'(MASTER_QTY - 1)) ? MSEL_W'(1)
                                                                   : pick_idx + MSEL_W'(1);
                  state_d  = StGrant;
               end else begin
                  msel_d    = '0;
                  busrq_n_d = 1'b1;
                  state_d   = StPark;
               end
            end else begin
               tcnt_d = tcnt_q - TcntW'(1);
            end
         end
         StGrant: begin
            if (req_n[msel_q]) begin
               ack_n_d = '1;
               state_d = StDrain;
            end
         end
         default: state_d = StPark;
      endcase
   end

   always_comb begin
      msel        = msel_q;
      ack_n       = ack_n_q;
      cpu_busrq_n = busrq_n_q;
      turn        = (state_q == StDrain) || (state_q == StTurn);
   end

endmodule

// File: tb/tb_sysarb.sv
// Directed bench for sysarb: a vector table on a 3-master/1-turn instance plus hand sequences
// on a 3-master/3-turn instance, with a continuous grant exclusivity monitor.
module tb_sysarb;
   import sysarb_pkg::*;

   typedef struct {
      logic       rst;
      logic [2:0] req_n;
      logic       busack_n;
      logic       rdn;
      logic [2:0] ack_n;
      logic       busrq_n;
      logic [1:0] msel;
      logic       turn;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: MASTER_QTY=3, TURN_CYCLES=1
   logic            rst_a = 1'b1;
   logic [2:0]      req_n_a = 3'b111;
   logic            busack_n_a = 1'b1;
   logic            rdn_a = 1'b1;
   z80_master_bus_t bus_a;
   logic [2:0]      ack_n_a;
   logic            busrq_n_a;
   logic [1:0]      msel_a;
   logic            turn_a;

   // Instance B: MASTER_QTY=3, TURN_CYCLES=3
   logic            rst_b = 1'b1;
   logic [2:0]      req_n_b = 3'b111;
   logic            busack_n_b = 1'b1;
   z80_master_bus_t bus_b;
   logic [2:0]      ack_n_b;
   logic            busrq_n_b;
   logic [1:0]      msel_b;
   logic            turn_b;

   always_comb begin
      bus_a       = '0;
      bus_a.mreqn = 1'b1;
      bus_a.iorqn = 1'b1;
      bus_a.wrn   = 1'b1;
      bus_a.rdn   = rdn_a;
      bus_b       = '0;
      bus_b.mreqn = 1'b1;
      bus_b.iorqn = 1'b1;
      bus_b.wrn   = 1'b1;
      bus_b.rdn   = 1'b1;
   end

   sysarb #(
      .MASTER_QTY  (3),
      .TURN_CYCLES (1)
   ) u_dut_a (
      .clk          (clk),
      .rst          (rst_a),
      .req_n        (req_n_a),
      .ack_n        (ack_n_a),
      .cpu_busrq_n  (busrq_n_a),
      .cpu_busack_n (busack_n_a),
      .bus_mon      (bus_a),
      .msel         (msel_a),
      .turn         (turn_a)
   );

   sysarb #(
      .MASTER_QTY  (3),
      .TURN_CYCLES (3)
   ) u_dut_b (
      .clk          (clk),
      .rst          (rst_b),
      .req_n        (req_n_b),
      .ack_n        (ack_n_b),
      .cpu_busrq_n  (busrq_n_b),
      .cpu_busack_n (busack_n_b),
      .bus_mon      (bus_b),
      .msel         (msel_b),
      .turn         (turn_b)
   );

   // At most one grant low, and only for the master that msel selects.
   always @(negedge clk) begin
      checks++;
      if (($countones(~ack_n_a) > 1) || ((ack_n_a != 3'b111) && (ack_n_a[msel_a] != 1'b0))) begin
         errors++;
         $display("FAIL ack_excl_a: ack_n=%b msel=%0d, required at most one low bit at msel",
                  ack_n_a, msel_a);
      end
      checks++;
      if (($countones(~ack_n_b) > 1) || ((ack_n_b != 3'b111) && (ack_n_b[msel_b] != 1'b0))) begin
         errors++;
         $display("FAIL ack_excl_b: ack_n=%b msel=%0d, required at most one low bit at msel",
                  ack_n_b, msel_b);
      end
   end

   function automatic vec_t v(input logic rst, input logic [2:0] req_n, input logic busack_n,
                              input logic rdn, input logic [2:0] ack_n, input logic busrq_n,
                              input logic [1:0] msel, input logic turn);
      vec_t r;
      r.rst = rst; r.req_n = req_n; r.busack_n = busack_n; r.rdn = rdn;
      r.ack_n = ack_n; r.busrq_n = busrq_n; r.msel = msel; r.turn = turn;
      return r;
   endfunction

   task automatic step_b(input logic [2:0] req_n, input logic busack_n, input logic [2:0] e_ack,
                         input logic e_busrq, input logic [1:0] e_msel, input logic e_turn,
                         input string name);
      req_n_b    = req_n;
      busack_n_b = busack_n;
      @(posedge clk);
      #1;
      checks++;
      if ({ack_n_b, busrq_n_b, msel_b, turn_b} !== {e_ack, e_busrq, e_msel, e_turn}) begin
         errors++;
         $display("FAIL %s: got ack_n=%b busrq_n=%b msel=%0d turn=%b, required %b %b %0d %b",
                  name, ack_n_b, busrq_n_b, msel_b, turn_b, e_ack, e_busrq, e_msel, e_turn);
      end
   endtask

   vec_t vecs[$];

   initial begin
      //                rst req_n busack rdn   ack_n  busrq msel turn
      // Reset held with master 1 requesting, then release
      vecs.push_back(v(1, 3'b101, 1, 1, 3'b111, 1, 0, 0));
      vecs.push_back(v(1, 3'b101, 1, 1, 3'b111, 1, 0, 0));
      vecs.push_back(v(0, 3'b101, 1, 1, 3'b111, 0, 0, 1));
      // CPU acks two cycles later, grant 1, then release back to PARK
      vecs.push_back(v(0, 3'b101, 1, 1, 3'b111, 0, 0, 1));
      vecs.push_back(v(0, 3'b101, 0, 1, 3'b111, 0, 0, 1));
      vecs.push_back(v(0, 3'b101, 0, 1, 3'b101, 0, 1, 0));
      vecs.push_back(v(0, 3'b101, 0, 1, 3'b101, 0, 1, 0));
      vecs.push_back(v(0, 3'b111, 0, 1, 3'b111, 0, 1, 1));
      vecs.push_back(v(0, 3'b111, 0, 1, 3'b111, 0, 1, 1));
      vecs.push_back(v(0, 3'b111, 0, 1, 3'b111, 1, 0, 0));
      vecs.push_back(v(0, 3'b111, 1, 1, 3'b111, 1, 0, 0));
      // Fresh reset, both 1 and 2 request: 1 then 2 then 1 again, CPU never reclaims
      vecs.push_back(v(1, 3'b111, 1, 1, 3'b111, 1, 0, 0));
      vecs.push_back(v(0, 3'b001, 1, 1, 3'b111, 0, 0, 1));
      vecs.push_back(v(0, 3'b001, 0, 1, 3'b111, 0, 0, 1));
      vecs.push_back(v(0, 3'b001, 0, 1, 3'b101, 0, 1, 0));
      vecs.push_back(v(0, 3'b011, 0, 1, 3'b111, 0, 1, 1));
      vecs.push_back(v(0, 3'b011, 0, 1, 3'b111, 0, 1, 1));
      vecs.push_back(v(0, 3'b011, 0, 1, 3'b011, 0, 2, 0));
      vecs.push_back(v(0, 3'b101, 0, 1, 3'b111, 0, 2, 1));
      vecs.push_back(v(0, 3'b101, 0, 1, 3'b111, 0, 2, 1));
      vecs.push_back(v(0, 3'b101, 0, 1, 3'b101, 0, 1, 0));
      // Release of 1 while rdn busy for three cycles keeps DRAIN and msel=1
      vecs.push_back(v(0, 3'b111, 0, 0, 3'b111, 0, 1, 1));
      vecs.push_back(v(0, 3'b111, 0, 0, 3'b111, 0, 1, 1));
      vecs.push_back(v(0, 3'b111, 0, 0, 3'b111, 0, 1, 1));
      vecs.push_back(v(0, 3'b111, 0, 1, 3'b111, 0, 1, 1));
      vecs.push_back(v(0, 3'b111, 0, 1, 3'b111, 1, 0, 0));
      // Grant 2 (CPU acks but bus busy one cycle), no preemption by 1, then reset mid-grant
      vecs.push_back(v(0, 3'b011, 1, 1, 3'b111, 0, 0, 1));
      vecs.push_back(v(0, 3'b011, 0, 0, 3'b111, 0, 0, 1));
      vecs.push_back(v(0, 3'b011, 0, 1, 3'b111, 0, 0, 1));
      vecs.push_back(v(0, 3'b011, 0, 1, 3'b011, 0, 2, 0));
      vecs.push_back(v(0, 3'b001, 0, 1, 3'b011, 0, 2, 0));
      vecs.push_back(v(1, 3'b011, 0, 1, 3'b111, 1, 0, 0));
      vecs.push_back(v(0, 3'b111, 1, 1, 3'b111, 1, 0, 0));

      foreach (vecs[i]) begin
         rst_a      = vecs[i].rst;
         req_n_a    = vecs[i].req_n;
         busack_n_a = vecs[i].busack_n;
         rdn_a      = vecs[i].rdn;
         @(posedge clk);
         #1;
         checks++;
         if ({ack_n_a, busrq_n_a, msel_a, turn_a} !==
             {vecs[i].ack_n, vecs[i].busrq_n, vecs[i].msel, vecs[i].turn}) begin
            errors++;
            $display("FAIL vec_%0d: got ack_n=%b busrq_n=%b msel=%0d turn=%b, required %b %b %0d %b",
                     i, ack_n_a, busrq_n_a, msel_a, turn_a, vecs[i].ack_n, vecs[i].busrq_n,
                     vecs[i].msel, vecs[i].turn);
         end
      end

      // Instance B: request withdrawn mid-TURN gives no grant and parks
      rst_b = 1'b1;
      step_b(3'b111, 1, 3'b111, 1, 0, 0, "b_reset");
      rst_b = 1'b0;
      step_b(3'b101, 1, 3'b111, 0, 0, 1, "b_drain");
      step_b(3'b101, 0, 3'b111, 0, 0, 1, "b_turn_enter");
      step_b(3'b111, 0, 3'b111, 0, 0, 1, "b_turn_wd1");
      step_b(3'b111, 0, 3'b111, 0, 0, 1, "b_turn_wd2");
      step_b(3'b111, 0, 3'b111, 1, 0, 0, "b_wd_park");
      // Full three-cycle turnaround: grant lands 2+3 edges after the request is sampled
      step_b(3'b011, 1, 3'b111, 0, 0, 1, "b_lat_drain");
      step_b(3'b011, 0, 3'b111, 0, 0, 1, "b_lat_turn0");
      step_b(3'b011, 0, 3'b111, 0, 0, 1, "b_lat_turn1");
      step_b(3'b011, 0, 3'b111, 0, 0, 1, "b_lat_turn2");
      step_b(3'b011, 0, 3'b011, 0, 2, 0, "b_lat_grant");
      step_b(3'b111, 0, 3'b111, 0, 2, 1, "b_rel_drain");
      step_b(3'b111, 0, 3'b111, 0, 2, 1, "b_rel_turn");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
